btn_conditioner: RTL

- Upstream front end for the whack-a-mole game top. Sits between the four raw whack pushbuttons and the game logic.
- Each button is synchronised to the 100 MHz clock and debounced. The block emits clean levels, one-cycle press and release pulses, and a simultaneous-press flag.
- The score logic uses that flag to reject "mash all buttons" cheating.
- Replaces direct use of raw button inputs by the score logic.

---
 rtl/game_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 107 ++++++++++
 rtl/btn_conditioner.sv | 51 +++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared constants and types for the whack-a-mole game.
// Used by the button front end and the score logic.
package game_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int DEBOUNCE_CYCLES_SIM     = 4;
    localparam int NUM_MOLES               = 4;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        ARM_HI    = 2'd1,
        STABLE_HI = 2'd2,
        ARM_LO    = 2'd3
    } debounce_state_e;

    // Counter width for a debounce of n cycles; never narrower than one bit.
    function automatic int debounce_cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, debounce FSM and counter.
// Level, press and release outputs are registered; press_next feeds the multi-press detector.
module debounce_channel
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            raw,
    output logic            level,
    output logic            press,
    output logic            released,
    output logic            press_next,
    output debounce_state_e state
);

    localparam int              CNT_W    = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    debounce_state_e  state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_d;
    logic             press_d;
    logic             release_d;

    // A glitch in either ARM state drops straight back to the stable state with a
    // cleared counter, so every acceptance needs a fresh unbroken run of samples.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt_q;
        level_d   = level;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state)
            STABLE_LO: begin
                if (sync2) begin
                    state_d = ARM_HI;
                    cnt_d   = '0;
                end
            end
            ARM_HI: begin
                if (!sync2) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!sync2) begin
                    state_d = ARM_LO;
                    cnt_d   = '0;
                end
            end
            ARM_LO: begin
                if (sync2) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = STABLE_LO;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            state    <= STABLE_LO;
            cnt_q    <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            state    <= state_d;
            cnt_q    <= cnt_d;
            level    <= level_d;
            press    <= press_d;
            released <= release_d;
        end
    end

    assign press_next = press_d;

endmodule

// File: rtl/btn_conditioner.sv
// Front end for the whack buttons: NUM_BTN independent debounce channels plus a
// registered flag for two or more presses accepted on the same cycle.
module btn_conditioner
    import game_pkg::*;
#(
    parameter int NUM_BTN         = NUM_MOLES,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               multi_press
);

    logic [NUM_BTN-1:0] press_next;
    debounce_state_e    chan_state [NUM_BTN];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .raw       (btn_raw[i]),
            .level     (btn_level[i]),
            .press     (btn_press[i]),
            .released  (btn_release[i]),
            .press_next(press_next[i]),
            .state     (chan_state[i])
        );

        a_level_matches_state: assert property (@(posedge clk) disable iff (reset)
            btn_level[i] == ((chan_state[i] == STABLE_HI) || (chan_state[i] == ARM_LO)));

        a_press_release_exclusive: assert property (@(posedge clk) disable iff (reset)
            !(btn_press[i] && btn_release[i]));
    end

    // Built from the next-state press vector so the flag lands on the same cycle as btn_press.
    always_ff @(posedge clk) begin
        if (reset) begin
            multi_press <= 1'b0;
        end else begin
            multi_press <= ($countones(press_next) >= 2);
        end
    end

endmodule
